// File: rtl/irq_pend_ctrl.sv
// Interrupt pending register with rising-edge capture and a lowest-index claim offer.
// Optional macro IRQ_PEND_SYNC_EN adds a 2-flop input synchroniser ahead of edge detection.
//   state | meaning
//   IDLE  | no claim offered; loads the lowest masked pending index when one exists
//   OFFER | io_claim_id offered with io_claim_valid=1, held until io_claim_ready
module irq_pend_ctrl #(
    parameter int NIRQ = 8,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] io_status_im,
    input  logic [NIRQ-1:0] io_irq_in,
    input  logic            io_clear_en,
    input  logic [NIRQ-1:0] io_clear_mask,
    output logic            io_claim_valid,
    input  logic            io_claim_ready,
    output logic [IDW-1:0]  io_claim_id,
    output logic [NIRQ-1:0] io_pending
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] irq_s;
    logic [NIRQ-1:0] irq_prev_q;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] masked, rise, clr, claim_oh;
    logic [IDW-1:0]  claim_id_q, cand;
    logic            cand_valid, load_id, handshake;

`ifdef IRQ_PEND_SYNC_EN
    logic [NIRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= io_irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = io_irq_in;
`endif

    assign rise   = irq_s & ~irq_prev_q;
    assign masked = pending_q & io_status_im;

    always_comb begin
        cand       = '0;
        cand_valid = 1'b0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                cand       = IDW'(i);
                cand_valid = 1'b1;
            end
        end
    end

    always_comb begin
        claim_oh = '0;
        for (int i = 0; i < NIRQ; i++) begin
            claim_oh[i] = (claim_id_q == IDW'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        load_id   = 1'b0;
        handshake = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand_valid) begin
                    load_id = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (io_claim_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new edge in the same cycle as a clear wins, so the OR comes last.
    always_comb begin
        clr       = ({NIRQ{io_clear_en}} & io_clear_mask) | ({NIRQ{handshake}} & claim_oh);
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            claim_id_q <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_s;
            pending_q  <= pending_d;
            if (load_id) begin
                claim_id_q <= cand;
            end
        end
    end

    assign io_claim_valid = (state_q == OFFER);
    assign io_claim_id    = claim_id_q;
    assign io_pending     = pending_q;

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Directed bench for irq_pend_ctrl: edge capture, masking, claim handshake, clears and reset.
// Honours IRQ_PEND_SYNC_EN by adding the synchroniser delay to every edge-to-pending wait.
module tb_irq_pend_ctrl;

    localparam int NIRQ = 8;
    localparam int IDW  = 3;
`ifdef IRQ_PEND_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NIRQ-1:0] io_status_im;
    logic [NIRQ-1:0] io_irq_in;
    logic            io_clear_en;
    logic [NIRQ-1:0] io_clear_mask;
    logic            io_claim_valid;
    logic            io_claim_ready;
    logic [IDW-1:0]  io_claim_id;
    logic [NIRQ-1:0] io_pending;

    int tests_run = 0;
    int tests_failed = 0;

    irq_pend_ctrl #(.NIRQ(NIRQ), .IDW(IDW)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_status_im  (io_status_im),
        .io_irq_in     (io_irq_in),
        .io_clear_en   (io_clear_en),
        .io_clear_mask (io_clear_mask),
        .io_claim_valid(io_claim_valid),
        .io_claim_ready(io_claim_ready),
        .io_claim_id   (io_claim_id),
        .io_pending    (io_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a new irq level and advance until the edge has landed in pending.
    task automatic edge_to_pending(input logic [NIRQ-1:0] lvl);
        io_irq_in = lvl;
        repeat (EXTRA + 1) tick();
    endtask

    // Drop all sources and let the edge history settle at zero.
    task automatic quiesce();
        io_irq_in = '0;
        repeat (EXTRA + 2) tick();
    endtask

    initial begin
        reset          = 1'b0;
        io_status_im   = '0;
        io_irq_in      = '0;
        io_clear_en    = 1'b0;
        io_clear_mask  = '0;
        io_claim_ready = 1'b0;
        repeat (3) tick();
        check("rst_pending", 32'(io_pending), 32'h00);
        check("rst_valid", 32'(io_claim_valid), 32'h0);
        check("rst_id", 32'(io_claim_id), 32'h0);
        reset = 1'b1;
        repeat (2) tick();
        check("idle_pending", 32'(io_pending), 32'h00);

        // Single source, full mask
        io_status_im = 8'hFF;
        edge_to_pending(8'h04);
        check("b2_pending", 32'(io_pending), 32'h04);
        check("b2_valid_early", 32'(io_claim_valid), 32'h0);
        tick();
        check("b2_valid", 32'(io_claim_valid), 32'h1);
        check("b2_id", 32'(io_claim_id), 32'h2);
        tick();
        check("b2_hold", 32'(io_claim_valid), 32'h1);
        io_claim_ready = 1'b1;
        tick();
        io_claim_ready = 1'b0;
        check("b2_hs_pending", 32'(io_pending), 32'h00);
        check("b2_hs_valid", 32'(io_claim_valid), 32'h0);
        tick();
        check("b2_steady_high", 32'(io_pending), 32'h00);

        // Two sources: lowest index first, next offer two cycles after handshake
        quiesce();
        edge_to_pending(8'h06);
        check("b12_pending", 32'(io_pending), 32'h06);
        tick();
        check("b12_id1", 32'(io_claim_id), 32'h1);
        io_claim_ready = 1'b1;
        tick();
        io_claim_ready = 1'b0;
        check("b12_pending_after", 32'(io_pending), 32'h04);
        check("b12_gap_valid", 32'(io_claim_valid), 32'h0);
        tick();
        check("b12_valid2", 32'(io_claim_valid), 32'h1);
        check("b12_id2", 32'(io_claim_id), 32'h2);
        io_claim_ready = 1'b1;
        tick();
        io_claim_ready = 1'b0;
        check("b12_empty", 32'(io_pending), 32'h00);

        // Masked source never offered
        quiesce();
        io_status_im = 8'hF0;
        edge_to_pending(8'h22);
        check("m_pending", 32'(io_pending), 32'h22);
        tick();
        check("m_id5", 32'(io_claim_id), 32'h5);
        io_claim_ready = 1'b1;
        tick();
        io_claim_ready = 1'b0;
        check("m_pending_after", 32'(io_pending), 32'h02);
        repeat (3) tick();
        check("m_bit1_not_offered", 32'(io_claim_valid), 32'h0);
        io_claim_ready = 1'b1;
        tick();
        io_claim_ready = 1'b0;
        check("m_ready_in_idle", 32'(io_pending), 32'h02);
        io_clear_en   = 1'b1;
        io_clear_mask = 8'h02;
        tick();
        io_clear_en = 1'b0;
        check("m_sw_clear", 32'(io_pending), 32'h00);

        // Set wins over clear in the same cycle
        quiesce();
        io_status_im = 8'h00;
        io_irq_in    = 8'h08;
        repeat (EXTRA) tick();
        io_clear_en   = 1'b1;
        io_clear_mask = 8'h08;
        tick();
        io_clear_en = 1'b0;
        check("setwins_pending", 32'(io_pending), 32'h08);
        io_clear_en = 1'b1;
        tick();
        io_clear_en = 1'b0;
        check("clear_alone", 32'(io_pending), 32'h00);

        // Offer stays stable while mask drops and software clears the bit
        quiesce();
        io_status_im = 8'hFF;
        edge_to_pending(8'h01);
        tick();
        check("stab_valid", 32'(io_claim_valid), 32'h1);
        check("stab_id", 32'(io_claim_id), 32'h0);
        io_status_im = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stab_hold_valid", 32'(io_claim_valid), 32'h1);
            check("stab_hold_id", 32'(io_claim_id), 32'h0);
        end
        io_clear_en   = 1'b1;
        io_clear_mask = 8'h01;
        tick();
        io_clear_en = 1'b0;
        check("stab_sw_clear_pending", 32'(io_pending), 32'h00);
        check("stab_sw_clear_valid", 32'(io_claim_valid), 32'h1);
        io_claim_ready = 1'b1;
        tick();
        io_claim_ready = 1'b0;
        check("stab_done_valid", 32'(io_claim_valid), 32'h0);
        check("stab_done_pending", 32'(io_pending), 32'h00);

        // Asynchronous reset mid-offer, source held high across release
        quiesce();
        io_status_im = 8'hFF;
        edge_to_pending(8'h01);
        tick();
        check("rs_offer", 32'(io_claim_valid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("rs_async_valid", 32'(io_claim_valid), 32'h0);
        check("rs_async_pending", 32'(io_pending), 32'h00);
        tick();
        check("rs_held_pending", 32'(io_pending), 32'h00);
        reset = 1'b1;
        repeat (EXTRA + 1) tick();
        check("rs_rel_pending", 32'(io_pending), 32'h01);
        check("rs_rel_valid_early", 32'(io_claim_valid), 32'h0);
        tick();
        check("rs_rel_valid", 32'(io_claim_valid), 32'h1);
        check("rs_rel_id", 32'(io_claim_id), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
